// File: rtl/mod_tick_cnt.sv
// Prescaled up/down modulo counter. A DIV_W-bit prescaler produces a tick every
// num enabled cycles. On each tick the count steps within 0..MAX, and carry flags a wrap.
module mod_tick_cnt #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59,
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] num,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1'b1);
  localparam logic [DIV_W-1:0] ZERO_D  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE_D   = DIV_W'(1'b1);

  logic [DIV_W-1:0] div_cnt_r, div_cnt_s;
  logic [WIDTH-1:0] out_r, out_s, out_step_s;
  logic             tick_r, tick_s, carry_r, carry_s;
  logic             terminal_s, wrap_s;

  // Terminal cycle detect; >= also covers num lowered below the running count.
  always_comb begin
    terminal_s = 1'b0;
    if (num <= ONE_D) begin
      terminal_s = 1'b1;
    end else begin
      terminal_s = (div_cnt_r >= (num - ONE_D));
    end
  end

  // Next count value for a tick, with wrap detection in either direction.
  always_comb begin
    out_step_s = out_r;
    wrap_s     = 1'b0;
    if (up_dn) begin
      if (out_r >= MAX_V) begin
        out_step_s = ZERO_W;
        wrap_s     = 1'b1;
      end else begin
        out_step_s = out_r + ONE_W;
      end
    end else begin
      if (out_r == ZERO_W) begin
        out_step_s = MAX_V;
        wrap_s     = 1'b1;
      end else begin
        out_step_s = out_r - ONE_W;
      end
    end
  end

  // Next-state selection: clr over load over the enabled prescaler/count update.
  always_comb begin
    div_cnt_s = div_cnt_r;
    out_s     = out_r;
    tick_s    = 1'b0;
    carry_s   = 1'b0;
    if (clr) begin
      div_cnt_s = ZERO_D;
      out_s     = ZERO_W;
    end else if (load) begin
      div_cnt_s = ZERO_D;
      out_s     = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (terminal_s) begin
        div_cnt_s = ZERO_D;
        tick_s    = 1'b1;
        carry_s   = wrap_s;
        out_s     = out_step_s;
      end else begin
        div_cnt_s = div_cnt_r + ONE_D;
      end
    end else begin
      div_cnt_s = div_cnt_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= ZERO_D;
      out_r     <= ZERO_W;
      tick_r    <= 1'b0;
      carry_r   <= 1'b0;
    end else begin
      div_cnt_r <= div_cnt_s;
      out_r     <= out_s;
      tick_r    <= tick_s;
      carry_r   <= carry_s;
    end
  end

  assign out   = out_r;
  assign tick  = tick_r;
  assign carry = carry_r;

endmodule

// File: tb/tb_mod_tick_cnt.sv
// Self-checking bench for mod_tick_cnt: an arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed tick intervals and output values.
module tb_mod_tick_cnt;

  localparam int WIDTH = 6;
  localparam int MAX   = 59;
  localparam int DIV_W = 32;

  logic             clk = 1'b0;
  logic             rst, en, up_dn, clr, load;
  logic [DIV_W-1:0] num;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tick, carry;

  int checks   = 0;
  int failures = 0;

  longint m_div   = 0;
  int     m_out   = 0;
  bit     m_tick  = 1'b0;
  bit     m_carry = 1'b0;
  bit     m_valid = 1'b0;

  mod_tick_cnt #(.WIDTH(WIDTH), .MAX(MAX), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .en(en), .num(num), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .out(out), .tick(tick), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit is_term(input longint d, input longint n);
    return (n <= 1) || (d >= n - 1);
  endfunction

  function automatic int next_out(input int o, input bit up);
    return up ? (o + 1) % (MAX + 1) : (o + MAX) % (MAX + 1);
  endfunction

  function automatic bit wraps(input int o, input bit up);
    return up ? (o == MAX) : (o == 0);
  endfunction

  // Reference model: count of enabled cycles modulo num, and a modulo-(MAX+1) counter.
  always @(posedge clk) begin
    if (rst) begin
      m_div <= 0; m_out <= 0; m_tick <= 1'b0; m_carry <= 1'b0; m_valid <= 1'b1;
    end else if (clr) begin
      m_div <= 0; m_out <= 0; m_tick <= 1'b0; m_carry <= 1'b0;
    end else if (load) begin
      m_div <= 0; m_tick <= 1'b0; m_carry <= 1'b0;
      m_out <= (int'(load_val) > MAX) ? MAX : int'(load_val);
    end else if (en && is_term(m_div, longint'(num))) begin
      m_div <= 0; m_tick <= 1'b1;
      m_carry <= wraps(m_out, up_dn);
      m_out <= next_out(m_out, up_dn);
    end else begin
      m_div <= en ? m_div + 1 : m_div;
      m_tick <= 1'b0; m_carry <= 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out", 64'(out), 64'(m_out));
      chk("model_tick", 64'(tick), 64'(m_tick));
      chk("model_carry", 64'(carry), 64'(m_carry));
    end
  end

  task automatic wait_tick(input int maxc, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tick !== 1'b1 && waited < maxc);
    chk("tick_seen", 64'(tick), 64'd1);
  endtask

  initial begin
    int w;
    int w2;
    rst = 1'b1; en = 1'b1; num = 32'd3; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = 6'd0;

    // Reset held two cycles with counting requested.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_tick", 64'(tick), 64'd0);
      chk("rst_carry", 64'(carry), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk); chk("rel_tick1", 64'(tick), 64'd0);
    @(negedge clk); chk("rel_tick2", 64'(tick), 64'd0);
    @(negedge clk); chk("rel_tick3", 64'(tick), 64'd1);
    chk("rel_out", 64'(out), 64'd1);

    // Full up-count revolution with num=5.
    clr = 1'b1; num = 32'd5; up_dn = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_out", 64'(out), 64'd0);
    for (int k = 1; k <= 60; k++) begin
      wait_tick(10, w);
      chk("up_interval", 64'(w), 64'd5);
      chk("up_out", 64'(out), 64'(k % 60));
      chk("up_carry", 64'(carry), (k == 60) ? 64'd1 : 64'd0);
    end

    // Down-count borrow at every-cycle rate.
    num = 32'd1; up_dn = 1'b0;
    @(negedge clk);
    chk("dn_out0", 64'(out), 64'd59);
    chk("dn_carry0", 64'(carry), 64'd1);
    chk("dn_tick0", 64'(tick), 64'd1);
    @(negedge clk);
    chk("dn_out1", 64'(out), 64'd58);
    chk("dn_carry1", 64'(carry), 64'd0);
    chk("dn_tick1", 64'(tick), 64'd1);

    // Load saturation, then clr beating load.
    load = 1'b1; load_val = 6'd63;
    @(negedge clk);
    chk("load_sat", 64'(out), 64'd59);
    chk("load_tick", 64'(tick), 64'd0);
    clr = 1'b1; load_val = 6'd10;
    @(negedge clk);
    chk("clr_load_out", 64'(out), 64'd0);
    chk("clr_load_tick", 64'(tick), 64'd0);
    chk("clr_load_carry", 64'(carry), 64'd0);
    load = 1'b0; clr = 1'b0;

    // Enable dropped mid-period stretches the interval.
    num = 32'd10; up_dn = 1'b1;
    wait_tick(20, w);
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    wait_tick(20, w);
    chk("en_gap_interval", 64'(10 + w), 64'd14);

    // Lowering num below the running prescaler count.
    repeat (7) @(negedge clk);
    num = 32'd3;
    wait_tick(5, w);
    chk("num_drop_interval", 64'(w), 64'd1);
    @(negedge clk);
    up_dn = 1'b0;
    wait_tick(5, w2);
    chk("dir_change_interval", 64'(1 + w2), 64'd3);
    wait_tick(5, w);
    chk("num3_interval", 64'(w), 64'd3);

    // Reset mid-period discards partial count and overrides load.
    num = 32'd4;
    repeat (2) @(negedge clk);
    rst = 1'b1; load = 1'b1; load_val = 6'd20;
    @(negedge clk);
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_tick", 64'(tick), 64'd0);
    rst = 1'b0; load = 1'b0;
    wait_tick(10, w);
    chk("midrst_interval", 64'(w), 64'd4);

    // Load still applies while disabled, and the count then holds.
    en = 1'b0; load = 1'b1; load_val = 6'd30;
    @(negedge clk);
    load = 1'b0;
    chk("dis_load_out", 64'(out), 64'd30);
    repeat (3) @(negedge clk);
    chk("dis_hold_out", 64'(out), 64'd30);
    chk("dis_hold_tick", 64'(tick), 64'd0);
    en = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
